// File: rtl/ram_scan_reader_pkg.sv
// Shared types and defaults for the RAM scan reader.
// Holds the FSM state encoding, the STEP/AUTO mode encoding and the
// default RAM geometry (32 words of 4 bits).
package ram_scan_reader_pkg;

   // Default RAM geometry
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_DATA_W = 4;

   // Read sequencing states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   // Trigger source selection
   typedef enum logic {
      MODE_STEP = 1'b0,
      MODE_AUTO = 1'b1
   } mode_t;

   // Flip between STEP and AUTO
   function automatic mode_t toggle_mode(input mode_t m);
      return (m == MODE_STEP) ? MODE_AUTO : MODE_STEP;
   endfunction

endpackage : ram_scan_reader_pkg

// File: rtl/ram_scan_reader_if.sv
// Bus bundle for the RAM scan reader: RAM port A plus the display outputs.
//
// Handshake: there is no ready. valid is a one-cycle strobe that is high
// for exactly the capture cycle of a read. dout, addr_out and has_data are
// registered and take their new values on the clock edge that closes that
// valid cycle, so a consumer samples them on the cycle after valid. They
// then hold until the next strobe (or reset).
interface ram_scan_reader_if
   import ram_scan_reader_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) ();

   // RAM port A
   logic [DATA_W-1:0] ram_douta;
   logic [ADDR_W-1:0] ram_addra;
   logic              ram_wea;

   // Display side
   logic [DATA_W-1:0] dout;
   logic [ADDR_W-1:0] addr_out;
   logic              valid;
   logic              has_data;
   logic              busy;
   logic              auto_mode;

   // FSM state, exposed for observation
   state_t            state;

   // The reader drives the RAM address and all display outputs
   modport master (
      input  ram_douta,
      output ram_addra,
      output ram_wea,
      output dout,
      output addr_out,
      output valid,
      output has_data,
      output busy,
      output auto_mode,
      output state
   );

   // The RAM/display side sees the mirror image
   modport slave (
      output ram_douta,
      input  ram_addra,
      input  ram_wea,
      input  dout,
      input  addr_out,
      input  valid,
      input  has_data,
      input  busy,
      input  auto_mode,
      input  state
   );

endinterface : ram_scan_reader_if

// File: rtl/ram_scan_reader_pulse_generator.sv
// Button pulse generator: two-flop synchroniser on the raw input followed
// by a rising-edge detector. One press (any length) yields exactly one
// single-cycle pulse, two clocks after the press is first sampled.
module pulse_generator (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic pulse
);

   logic sync_1;
   logic sync_2;
   logic prev;

   // Synchronise the raw button and remember the previous synchronised level
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_1 <= 1'b0;
         sync_2 <= 1'b0;
         prev   <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         prev   <= sync_2;
      end
   end

   // Rising edge of the synchronised level
   assign pulse = sync_2 & ~prev;

endmodule : pulse_generator

// File: rtl/ram_scan_reader.sv
// RAM scan reader: walks the read port of the task RAM one address at a
// time and latches each word together with its address for display.
// Reads are triggered by the step button (STEP mode) or by a free-running
// scan timer (AUTO mode); the mode button toggles between the two.
// The reader never writes, so ram_wea is held low and a writer may share
// the port while busy is low.
module ram_scan_reader
   import ram_scan_reader_pkg::*;
#(
   parameter int ADDR_W    = DEF_ADDR_W,
   parameter int DATA_W    = DEF_DATA_W,
   parameter int LAST_ADDR = 31,
   parameter int RD_LAT    = 1,
   parameter int SCAN_DIV  = 100000000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_step,
   input  logic              btn_mode,
   ram_scan_reader_if.master bus
);

   // Timer wide enough to hold SCAN_DIV-1; wait counter wide enough for RD_LAT
   localparam int TIMER_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int WAIT_W  = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(SCAN_DIV - 1);
   localparam logic [ADDR_W-1:0]  LAST_A    = ADDR_W'(LAST_ADDR);
   localparam logic [WAIT_W-1:0]  WAIT_INIT = WAIT_W'(RD_LAT);
   localparam logic [WAIT_W-1:0]  WAIT_ONE  = WAIT_W'(1);

   logic step_p;
   logic mode_p;

   state_t             state;
   mode_t              mode;
   logic [TIMER_W-1:0] scan_timer;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [ADDR_W-1:0]  rd_addr;
   logic [ADDR_W-1:0]  addra_r;
   logic [DATA_W-1:0]  dout_r;
   logic [ADDR_W-1:0]  addr_out_r;
   logic               valid_r;
   logic               has_data_r;

   logic               timer_hit;
   logic               trigger;
   logic [ADDR_W-1:0]  rd_addr_next;

   // One pulse per press for each button
   pulse_generator u_step_pulse (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_step),
      .pulse (step_p)
   );

   pulse_generator u_mode_pulse (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_mode),
      .pulse (mode_p)
   );

   // The trigger uses the mode held before any toggle in this cycle, so a
   // step arriving together with a mode press still counts as a STEP read.
   assign timer_hit    = (mode == MODE_AUTO) && (scan_timer == TIMER_MAX);
   assign trigger      = (mode == MODE_AUTO) ? timer_hit : step_p;

   // Explicit compare keeps the wrap correct when LAST_ADDR is below 2^ADDR_W-1
   assign rd_addr_next = (rd_addr == LAST_A) ? '0 : rd_addr + 1'b1;

   // Mode register: toggled by each mode press
   always_ff @(posedge clk) begin
      if (rst) begin
         mode <= MODE_STEP;
      end else if (mode_p) begin
         mode <= toggle_mode(mode);
      end
   end

   // Scan timer: free-runs modulo SCAN_DIV in AUTO, parked at 0 otherwise
   always_ff @(posedge clk) begin
      if (rst) begin
         scan_timer <= '0;
      end else if (mode_p || (mode == MODE_STEP)) begin
         scan_timer <= '0;
      end else if (scan_timer == TIMER_MAX) begin
         scan_timer <= '0;
      end else begin
         scan_timer <= scan_timer + 1'b1;
      end
   end

   // Read sequencer: issue address, wait out the RAM latency, capture.
   // Triggers outside IDLE are simply ignored, never queued.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         wait_cnt   <= '0;
         rd_addr    <= '0;
         addra_r    <= '0;
         dout_r     <= '0;
         addr_out_r <= '0;
         valid_r    <= 1'b0;
         has_data_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               valid_r <= 1'b0;
               if (trigger) begin
                  addra_r  <= rd_addr;
                  wait_cnt <= WAIT_INIT;
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               // valid is registered so that it is high during CAPTURE only
               wait_cnt <= wait_cnt - 1'b1;
               if (wait_cnt == WAIT_ONE) begin
                  state   <= ST_CAPTURE;
                  valid_r <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               dout_r     <= bus.ram_douta;
               addr_out_r <= addra_r;
               has_data_r <= 1'b1;
               rd_addr    <= rd_addr_next;
               valid_r    <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               valid_r <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   // Outputs onto the bus
   assign bus.ram_addra = addra_r;
   assign bus.ram_wea   = 1'b0;
   assign bus.dout      = dout_r;
   assign bus.addr_out  = addr_out_r;
   assign bus.valid     = valid_r;
   assign bus.has_data  = has_data_r;
   assign bus.busy      = (state != ST_IDLE);
   assign bus.auto_mode = (mode == MODE_AUTO);
   assign bus.state     = state;

endmodule : ram_scan_reader
